// File: rtl/bulk_echo_pkg.sv
// Shared types for the bulk echo block: output-stage state encoding.
package bulk_echo_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

endpackage

// File: rtl/bulk_echo_if.sv
// CDC bulk pipe between usb_cdc (master) and the application side (slave).
interface bulk_echo_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  modport slave (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );

endinterface

// File: rtl/bulk_echo_fifo.sv
// DEPTH x 8 synchronous FIFO; AW+1-bit pointers, MSB distinguishes full from empty.
module bulk_echo_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        push_i,
  input  logic [7:0]  wdata_i,
  input  logic        pop_i,
  output logic [7:0]  rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bulk_echo.sv
// Echoes CDC OUT bytes back on the IN stream, incremented by INC, through a
// FIFO plus one output register; drives a stretched activity LED.
module bulk_echo
  import bulk_echo_pkg::*;
#(
  parameter  int         DEPTH      = 16,
  parameter  logic [7:0] INC        = 8'd1,
  parameter  int         LED_CYCLES = 800000,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  bulk_echo_if.slave  cdc,
  output logic [AW:0] level_o,
  output logic        led_o
);

  localparam int LW = $clog2(LED_CYCLES + 1);

  stage_e      state_q, state_d;
  logic [7:0]  in_data_q, in_data_d;
  logic        out_ready_q, out_ready_d;
  logic [LW-1:0] led_cnt_q, led_cnt_d;
  logic        led_q;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [AW:0] fifo_level, level_d;
  logic        accept, deliver;

  assign accept  = cdc.out_valid & out_ready_q & ~fifo_full;
  assign deliver = (state_q == ST_FULL) & cdc.in_ready;

  bulk_echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (accept),
    .wdata_i (cdc.out_data + INC),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (!fifo_empty)                   state_d = ST_FULL;
      ST_FULL:  if (cdc.in_ready && fifo_empty)     state_d = ST_EMPTY;
      default:                                      state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      ST_EMPTY: fifo_pop = ~fifo_empty;
      ST_FULL:  fifo_pop = cdc.in_ready & ~fifo_empty;
      default:  fifo_pop = 1'b0;
    endcase
  end

  // Ready reflects occupancy after this edge, so a pop at full frees a slot one cycle later.
  assign level_d     = fifo_level + (AW+1)'(accept) - (AW+1)'(fifo_pop);
  assign out_ready_d = (level_d < (AW+1)'(DEPTH));
  assign in_data_d   = fifo_pop ? fifo_rdata : in_data_q;

  always_comb begin
    led_cnt_d = led_cnt_q;
    if (accept || deliver)     led_cnt_d = LW'(LED_CYCLES);
    else if (led_cnt_q != '0)  led_cnt_d = led_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_data_q   <= '0;
      out_ready_q <= 1'b0;
      led_cnt_q   <= '0;
      led_q       <= 1'b0;
    end else begin
      in_data_q   <= in_data_d;
      out_ready_q <= out_ready_d;
      led_cnt_q   <= led_cnt_d;
      led_q       <= (led_cnt_d != '0);
    end
  end

  assign cdc.out_ready = out_ready_q;
  assign cdc.in_valid  = (state_q == ST_FULL);
  assign cdc.in_data   = in_data_q;
  assign level_o       = fifo_level;
  assign led_o         = led_q;

endmodule
